bist_checker: RTL



---
 rtl/bist_checker_pkg.sv | 17 +
 rtl/bist_checker_run_len_counter.sv | 29 ++
 rtl/bist_checker.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/bist_checker_pkg.sv
// Shared definitions for the BIST response checker: FSM state encoding and
// error codes reported on err_code.
package bist_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_LEN   = 2'd1;
    localparam logic [1:0] ERR_ABORT = 2'd2;
    localparam logic [1:0] ERR_END   = 2'd3;

endpackage

// File: rtl/bist_checker_run_len_counter.sv
// Load-to-one / increment counter that flags when the count equals LIMIT.
// Used to measure the length of each OUT-high segment.
module run_len_counter #(
    parameter int WIDTH = 5,
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic i_load,
    input  logic i_inc,
    output logic o_eq_limit
);

    logic [WIDTH-1:0] r_count;

    // Load wins over increment: a load marks the first high sample of a segment.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= WIDTH'(1);
        end else if (i_inc) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_eq_limit = (r_count == WIDTH'(LIMIT));

endmodule

// File: rtl/bist_checker.sv
// Checks the segmented OUT stream of the BIST controller: M_SEGS segments of
// N_LEN high cycles separated by single gaps, then a clean BIST_END.
module bist_checker
    import bist_pkg::*;
#(
    parameter int N_LEN  = 16,
    parameter int M_SEGS = 13
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        Running,
    input  logic                        OUT,
    input  logic                        BIST_END,
    output logic                        CHECK_DONE,
    output logic                        PASS,
    output logic                        FAIL,
    output logic [1:0]                  err_code,
    output logic [$clog2(M_SEGS+1)-1:0] seg_count
);

    localparam int HI_W  = $clog2(N_LEN + 1);
    localparam int SEG_W = $clog2(M_SEGS + 1);
    localparam logic [SEG_W:0]   SEG_LIM = (SEG_W + 1)'(M_SEGS);
    localparam logic [SEG_W-1:0] SEG_MAX = SEG_W'(M_SEGS);

    state_t           r_state;
    logic             r_check_done;
    logic             r_pass;
    logic             r_fail;
    logic [1:0]       r_err;
    logic [SEG_W-1:0] r_seg_count;

    logic             w_hi_eq;
    logic [SEG_W:0]   w_seg_next;
    logic             w_start;
    logic             w_load;
    logic             w_inc;
    logic             w_to_gap;
    logic             w_to_high;
    logic             w_seg_inc;
    logic             w_judge;
    logic             w_pass;
    logic [1:0]       w_err;

    run_len_counter #(
        .WIDTH (HI_W),
        .LIMIT (N_LEN)
    ) u_hi_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_inc      (w_inc),
        .o_eq_limit (w_hi_eq)
    );

    assign w_seg_next = {1'b0, r_seg_count} + 1'b1;

    always_comb begin
        w_start   = 1'b0;
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_to_gap  = 1'b0;
        w_to_high = 1'b0;
        w_seg_inc = 1'b0;
        w_judge   = 1'b0;
        w_pass    = 1'b0;
        w_err     = ERR_NONE;
        case (r_state)
            HIGH: begin
                if (Running) begin
                    if (OUT) begin
                        if (w_hi_eq) begin
                            w_judge = 1'b1;
                            w_err   = ERR_LEN;
                        end else begin
                            w_inc = 1'b1;
                        end
                    end else if (!w_hi_eq) begin
                        w_judge = 1'b1;
                        w_err   = ERR_LEN;
                    end else begin
                        // A gap after the final segment means the stream ran long.
                        w_seg_inc = 1'b1;
                        if (w_seg_next >= SEG_LIM) begin
                            w_judge = 1'b1;
                            w_err   = ERR_END;
                        end else begin
                            w_to_gap = 1'b1;
                        end
                    end
                end else if (BIST_END) begin
                    w_judge = 1'b1;
                    if (w_hi_eq && (w_seg_next == SEG_LIM)) begin
                        w_seg_inc = 1'b1;
                        w_pass    = 1'b1;
                    end else if (!w_hi_eq) begin
                        w_err = ERR_LEN;
                    end else begin
                        w_err = ERR_END;
                    end
                end else begin
                    w_judge = 1'b1;
                    w_err   = ERR_ABORT;
                end
            end
            GAP: begin
                if (Running) begin
                    if (OUT) begin
                        w_load    = 1'b1;
                        w_to_high = 1'b1;
                    end else begin
                        w_judge = 1'b1;
                        w_err   = ERR_LEN;
                    end
                end else begin
                    w_judge = 1'b1;
                    w_err   = BIST_END ? ERR_END : ERR_ABORT;
                end
            end
            default: begin
                if (Running) begin
                    if (OUT) begin
                        w_start = 1'b1;
                        w_load  = 1'b1;
                    end else begin
                        w_judge = 1'b1;
                        w_err   = ERR_LEN;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= IDLE;
            r_check_done <= 1'b0;
            r_pass       <= 1'b0;
            r_fail       <= 1'b0;
            r_err        <= ERR_NONE;
            r_seg_count  <= '0;
        end else begin
            if (w_start) begin
                r_state      <= HIGH;
                r_check_done <= 1'b0;
                r_pass       <= 1'b0;
                r_fail       <= 1'b0;
                r_err        <= ERR_NONE;
                r_seg_count  <= '0;
            end else begin
                if (w_judge) begin
                    r_state      <= DONE;
                    r_check_done <= 1'b1;
                    r_pass       <= w_pass;
                    r_fail       <= !w_pass;
                    r_err        <= w_err;
                end else if (w_to_gap) begin
                    r_state <= GAP;
                end else if (w_to_high) begin
                    r_state <= HIGH;
                end
                if (w_seg_inc && (r_seg_count != SEG_MAX)) begin
                    r_seg_count <= r_seg_count + 1'b1;
                end
            end
        end
    end

    assign CHECK_DONE = r_check_done;
    assign PASS       = r_pass;
    assign FAIL       = r_fail;
    assign err_code   = r_err;
    assign seg_count  = r_seg_count;

endmodule
